// File: rtl/fp_sqrt_pkg.sv
// fp_sqrt_pkg: shared types and constants for the iterative FP square root.
// FPSQRT_ROUND_EN selects the 25-iteration rounded datapath.
package fp_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] QNAN = 32'h7FFFFFFF;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] ZERO = 32'h00000000;
    localparam int          BIAS = 127;

    localparam int ITERS_RND = 25;
    localparam int ITERS_TRN = 24;

`ifdef FPSQRT_ROUND_EN
    localparam int NITER = ITERS_RND;
`else
    localparam int NITER = ITERS_TRN;
`endif

    // Radicand holds two bits per iteration; remainder needs headroom.
    localparam int RADW = 2 * NITER;
    localparam int REMW = NITER + 3;

endpackage

// File: rtl/fp_sqrt_iter_checkspecial.sv
// checkspecial: classifies a single-precision operand.
// Pure combinational; denormals report as zero.
module checkspecial (
    input  logic [31:0] a_i,
    output logic        is_nan_o,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_neg_o
);

    assign is_nan_o  = (&a_i[30:23]) & (|a_i[22:0]);
    assign is_inf_o  = (&a_i[30:23]) & ~(|a_i[22:0]);
    assign is_zero_o = ~(|a_i[30:23]);
    assign is_neg_o  = a_i[31];

endmodule

// File: rtl/fp_sqrt_iter.sv
// fp_sqrt_iter: restoring digit-by-digit IEEE-754 single square root.
// Build option FPSQRT_ROUND_EN: guard bit plus round-to-nearest step.
module fp_sqrt_iter
    import fp_sqrt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] S,
    output logic        busy
);

    localparam logic [4:0] LAST = 5'(NITER - 1);

    state_e            state_q;
    logic [4:0]        cnt_q;
    logic [RADW-1:0]   rad_q, rad_d, rad_ld;
    logic [REMW-1:0]   rem_q, rem_d, rem_t, trial;
    logic [NITER-1:0]  root_q, root_d;
    logic [7:0]        exp_q, exp_d;
    logic              spec_q, spec_d;
    logic [31:0]       sval_q, sval_d;
    logic [31:0]       s_q;
    logic              ov_q;
    logic [31:0]       trn_s;
    logic              is_nan, is_zero, is_inf, is_neg;

    checkspecial u_chk (
        .a_i       (A),
        .is_nan_o  (is_nan),
        .is_zero_o (is_zero),
        .is_inf_o  (is_inf),
        .is_neg_o  (is_neg)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign S         = s_q;

    // Operand preparation: special result, exponent, aligned radicand.
    always_comb begin
        spec_d = 1'b1;
        sval_d = QNAN;
        if (is_nan) begin
            sval_d = QNAN;
        end else if (is_zero) begin
            sval_d = ZERO;
        end else if (is_inf && !is_neg) begin
            sval_d = PINF;
        end else if (is_neg) begin
            sval_d = QNAN;
        end else begin
            spec_d = 1'b0;
            sval_d = ZERO;
        end
        exp_d  = 8'((9'(A[30:23]) + 9'(BIAS)) >> 1);
        rad_ld = (RADW'({1'b1, A[22:0]}) << (RADW - 25))
                 << (A[23] ? 0 : 1);
    end

    // One restoring root step: bring down two bits, try 4q+1.
    always_comb begin
        rem_t = (rem_q << 2) | REMW'(rad_q[RADW-1 -: 2]);
        trial = (REMW'(root_q) << 2) | REMW'(1);
        rad_d = rad_q << 2;
        if (rem_t >= trial) begin
            rem_d  = rem_t - trial;
            root_d = (root_q << 1) | NITER'(1);
        end else begin
            rem_d  = rem_t;
            root_d = root_q << 1;
        end
    end

    assign trn_s = {1'b0, exp_q, root_d[22:0]};

`ifdef FPSQRT_ROUND_EN
    logic [22:0] mant_r;
    logic        carry_r;
    logic [31:0] rnd_s;
    // Carry out only when every root bit including guard is set.
    assign carry_r = &root_q;
    assign mant_r  = root_q[23:1] + 23'(root_q[0]);
    assign rnd_s   = {1'b0, exp_q + 8'(carry_r), mant_r};
`endif

    // Control FSM with registered result and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            exp_q   <= '0;
            spec_q  <= 1'b0;
            sval_q  <= '0;
            s_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        root_q  <= '0;
                        rad_q   <= rad_ld;
                        exp_q   <= exp_d;
                        spec_q  <= spec_d;
                        sval_q  <= sval_d;
                    end
                end
                CALC: begin
                    if (spec_q) begin
                        s_q     <= sval_q;
                        ov_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rad_q  <= rad_d;
                        rem_q  <= rem_d;
                        root_q <= root_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == LAST) begin
`ifdef FPSQRT_ROUND_EN
                            state_q <= ROUND;
`else
                            s_q     <= trn_s;
                            ov_q    <= 1'b1;
                            state_q <= DONE;
`endif
                        end
                    end
                end
                ROUND: begin
`ifdef FPSQRT_ROUND_EN
                    s_q     <= rnd_s;
                    ov_q    <= 1'b1;
                    state_q <= DONE;
`else
                    state_q <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        ov_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// tb_fp_sqrt_iter: vector table, corner sequences and randomized
// operands checked against an integer-sqrt reference model.
module tb_fp_sqrt_iter;

`ifdef FPSQRT_ROUND_EN
    localparam bit RND = 1'b1;
    localparam int LN  = 26;
`else
    localparam bit RND = 1'b0;
    localparam int LN  = 24;
`endif

    localparam logic [31:0] T_QNAN = 32'h7FFFFFFF;
    localparam logic [31:0] T_PINF = 32'h7F800000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        busy;

    int passed = 0;
    int total  = 0;

    fp_sqrt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: classify, then floor integer square root of the
    // scaled significand; optional round-half-up on a guard bit.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
        logic [7:0]      ee;
        int              e, h, n;
        longint unsigned rad, q, r;
        logic [7:0]      ex;
        logic [22:0]     mt;
        ee = a[30:23];
        if (ee == 8'hFF && a[22:0] != 0) return T_QNAN;
        if (ee == 8'h00) return 32'h0;
        if (ee == 8'hFF) return a[31] ? T_QNAN : T_PINF;
        if (a[31]) return T_QNAN;
        e = int'(ee) - 127;
        h = (e - (e & 1)) / 2;
        ex = 8'(h + 127);
        n = RND ? 25 : 24;
        rad = longint'({1'b1, a[22:0]});
        rad = rad << (2 * n - 25 + (e & 1));
        q = longint'($sqrt(real'(rad)));
        while (q * q > rad) q--;
        while ((q + 1) * (q + 1) <= rad) q++;
        if (RND) begin
            r = (q >> 1) + (q & 1);
            if (r >= (64'd1 << 24)) begin
                mt = 23'd0;
                ex = ex + 8'd1;
            end else begin
                mt = r[22:0];
            end
        end else begin
            mt = q[22:0];
        end
        return {1'b0, ex, mt};
    endfunction

    function automatic bit is_spec(input logic [31:0] a);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) || a[31];
    endfunction

    // Present one operand, wait for out_valid; lat=-1 on timeout.
    task automatic apply(input logic [31:0] a, output int lat,
                         output logic [31:0] s);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        A = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 64);
        lat = out_valid ? n : -1;
        s = S;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t        tbl[13];
    int          lat;
    logic [31:0] s;
    logic [31:0] a;
    bit          seen;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;

        tbl[0]  = '{32'h40800000, 32'h40000000, LN};
        tbl[1]  = '{32'h40000000, 32'h3FB504F3, LN};
        tbl[2]  = '{32'hC0800000, T_QNAN,       1};
        tbl[3]  = '{32'h7F800000, T_PINF,       1};
        tbl[4]  = '{32'h80000000, 32'h00000000, 1};
        tbl[5]  = '{32'h41100000, 32'h40400000, LN};
        tbl[6]  = '{32'h7FC00000, T_QNAN,       1};
        tbl[7]  = '{32'hFF800000, T_QNAN,       1};
        tbl[8]  = '{32'h00400000, 32'h00000000, 1};
        tbl[9]  = '{32'h3E800000, 32'h3F000000, LN};
        tbl[10] = '{32'h3F800000, 32'h3F800000, LN};
        tbl[11] = '{32'h3F000000, 32'h3F3504F3, LN};
        tbl[12] = '{32'h7F7FFFFF, 32'h5F7FFFFF, LN};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_S", S, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].a, lat, s);
            chk($sformatf("tbl%0d_S", i), s, tbl[i].s);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            consume();
            chk($sformatf("tbl%0d_ov_low", i), 32'(out_valid), 32'd0);
        end

        // Back-pressure: result held five cycles, new operands ignored.
        apply(32'h40800000, lat, s);
        chk("hold_first_S", s, 32'h40000000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1;
            A = 32'h41100000;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_S", k), S, 32'h40000000);
            chk($sformatf("hold%0d_ov", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("hs_ov_low", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_not_accepted", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("hs_idle_after", 32'(busy), 32'd0);

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        A = 32'h40800000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_S", S, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_output", 32'(seen), 32'd0);
        apply(32'h41100000, lat, s);
        chk("midrst_next_S", s, 32'h40400000);
        chk("midrst_next_lat", 32'(lat), 32'(LN));
        consume();

        // Randomized operands against the reference model.
        for (int i = 0; i < 150; i++) begin
            a = $urandom();
            if (i % 4 != 0) begin
                a[31] = 1'b0;
                a[30:23] = 8'($urandom_range(1, 254));
            end
            apply(a, lat, s);
            chk($sformatf("rnd%0d_S a=%h", i, a), s, ref_sqrt(a));
            chk($sformatf("rnd%0d_lat a=%h", i, a), 32'(lat),
                32'(is_spec(a) ? 1 : LN));
            consume();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_sqrt_iter.md
FP_SQRT_ITER -- requirements
Module: fp_sqrt_iter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  operand A is presented.
REQ-004 SHALL have port in_ready  output  1  block can accept an operand.
REQ-005 SHALL have port A  input  32  IEEE-754 single-precision operand.
REQ-006 SHALL have port out_valid  output  1  S holds a result.
REQ-007 SHALL have port out_ready  input  1  consumer takes S.
REQ-008 SHALL have port S  output  32  IEEE-754 single-precision square root of A.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL use FSM states IDLE, CALC, ROUND, DONE; in_ready = (state==IDLE).
REQ-011 SHALL accept A on the rising edge where in_valid && in_ready, register A, and leave IDLE.
REQ-012 SHALL classify A at acceptance, with precedence NaN > zero > Inf > negative:
- NaN -> 32'h7FFFFFFF
- exponent field 0 (either sign, denormals flushed) -> 32'h00000000
- +Inf -> 32'h7F800000
- -Inf or any negative nonzero -> 32'h7FFFFFFF
REQ-013 SHALL, for a special case, go directly to DONE with S set; out_valid rises 1 cycle after acceptance.
REQ-014 SHALL, for normal positive A with unbiased exponent e = E-127:
- result exponent = floor(e/2)+127
- radicand = 1.m, shifted left 1 bit when e is odd.
REQ-015 SHALL compute the root with a restoring digit-by-digit algorithm in CALC, one result bit per cycle, with an internal iteration counter.
REQ-016 SHALL, with rounding enabled (REQ-027):
- run 25 CALC iterations (24 mantissa bits plus 1 guard bit), then spend 1 cycle in ROUND
- out_valid rises 26 cycles after acceptance.
REQ-017 SHALL round to nearest by adding the guard bit; on mantissa carry-out to 2.0, mantissa = 0 and exponent += 1.
REQ-018 SHALL set S sign bit to 0 for every normal result.
REQ-019 SHALL hold S and out_valid stable in DONE until out_ready is high, then return to IDLE on that edge with out_valid low.
REQ-020 SHALL ignore in_valid when not in IDLE; an operand is never accepted in the same cycle as an output handshake.
REQ-021 SHALL keep S unchanged outside DONE; S is qualified only by out_valid.

Reset
REQ-022 SHALL, while rst_n is low, force state=IDLE, out_valid=0, S=32'h00000000, busy=0, and the iteration counter and datapath registers to 0.
REQ-023 SHALL, on reset assertion mid-CALC/ROUND/DONE, discard the in-flight operation with no output produced.
REQ-024 SHALL have in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL recognise the macro FPSQRT_ROUND_EN.
REQ-026 SHALL, without FPSQRT_ROUND_EN:
- omit the ROUND state and guard bit
- run 24 CALC iterations, truncate the result, pack on the last iteration
- out_valid rises 24 cycles after acceptance.
REQ-027 SHALL, with FPSQRT_ROUND_EN defined, behave per REQ-016/REQ-017.

Structure
REQ-028 SHALL take from shared package fp_sqrt_pkg:
- the state enum typedef
- constants QNAN=32'h7FFFFFFF, PINF=32'h7F800000, ZERO=32'h00000000, BIAS=127
- iteration counts (25 rounded / 24 truncated).
REQ-029 SHALL instantiate existing sub-module checkspecial for NaN/Inf/zero classification of A; no other sub-modules.

Verification
REQ-030 SHALL cover: A=32'h40800000 (4.0) -> S=32'h40000000, out_valid 26 cycles after acceptance (24 without macro).
REQ-031 SHALL cover: A=32'h40000000 (2.0) -> S=32'h3FB504F3 in both configurations.
REQ-032 SHALL cover: A=32'hC0800000 -> 32'h7FFFFFFF; A=32'h7F800000 -> 32'h7F800000; A=32'h80000000 -> 32'h00000000; each 1 cycle after acceptance.
REQ-033 SHALL cover: result ready with out_ready low for 5 cycles -> S and out_valid held constant, in_ready low; handshake on cycle 6 -> IDLE next cycle.
REQ-034 SHALL cover: rst_n pulsed low at CALC iteration 10 -> out_valid stays 0, in_ready=1 after release; next operand 32'h41100000 (9.0) -> 32'h40400000.
